// File: rtl/traffic_phase_timer_if.sv
// Bundle of light-controller phase inputs, pedestrian button and timer outputs.
// Handshake: advance is a one-cycle command pulse with no ready; the controller
// acknowledges it only by presenting a new one-hot phase on
// phase_red/phase_yellow/phase_green, and the timer re-issues advance
// periodically until that new phase is seen.
interface traffic_phase_timer_if;
   logic phase_red;
   logic phase_yellow;
   logic phase_green;
   logic ped_req;
   logic advance;
   logic walk;
   logic ped_pending;
   logic fault;

   // Light controller / environment side.
   modport master (
      output phase_red, phase_yellow, phase_green, ped_req,
      input  advance, walk, ped_pending, fault
   );

   // Phase timer side.
   modport slave (
      input  phase_red, phase_yellow, phase_green, ped_req,
      output advance, walk, ped_pending, fault
   );
endinterface

// File: rtl/traffic_phase_timer.sv
// Phase timer for a traffic light controller: times each phase, commands the
// controller to step with a one-cycle advance pulse, retries the command until
// the phase actually changes, shortens green for a pending pedestrian, grants
// walk on red entry and flags illegal (non one-hot) phase inputs.
module traffic_phase_timer #(
   parameter int RED_CYCLES    = 20,
   parameter int GREEN_CYCLES  = 30,
   parameter int YELLOW_CYCLES = 5,
   parameter int PED_GREEN     = 8,
   parameter int RETRY_CYCLES  = 4,
   parameter int CNT_W         = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   traffic_phase_timer_if.slave bus,
   output logic [1:0]           dbg_state
);

   // FSM encoding.
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_COUNT = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_FAULT = 2'd3;

   // Phase vector ordering is {red, yellow, green}.
   localparam logic [2:0] PH_RED    = 3'b100;
   localparam logic [2:0] PH_YELLOW = 3'b010;
   localparam logic [2:0] PH_GREEN  = 3'b001;

   // A zero duration behaves as one cycle so the counter can never underflow.
   localparam int RED_D    = (RED_CYCLES    < 1) ? 1 : RED_CYCLES;
   localparam int GREEN_D  = (GREEN_CYCLES  < 1) ? 1 : GREEN_CYCLES;
   localparam int YELLOW_D = (YELLOW_CYCLES < 1) ? 1 : YELLOW_CYCLES;
   localparam int PED_D    = (PED_GREEN     < 1) ? 1 : PED_GREEN;
   localparam int RETRY_D  = (RETRY_CYCLES  < 1) ? 1 : RETRY_CYCLES;

   localparam logic [CNT_W-1:0] RED_L    = CNT_W'(RED_D);
   localparam logic [CNT_W-1:0] GREEN_L  = CNT_W'(GREEN_D);
   localparam logic [CNT_W-1:0] YELLOW_L = CNT_W'(YELLOW_D);
   localparam logic [CNT_W-1:0] PED_L    = CNT_W'(PED_D);
   localparam logic [CNT_W-1:0] RETRY_L  = CNT_W'(RETRY_D);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   logic [1:0]       state;
   logic [2:0]       prev_phase;
   // Counter holds the number of edges left up to and including the edge
   // that raises advance.
   logic [CNT_W-1:0] cnt;

   logic [2:0]       phase;
   logic             legal;
   logic             entry;
   logic             is_red;
   logic             ped_set;
   logic             grant;
   logic [CNT_W-1:0] load_val;
   logic [CNT_W-1:0] eff_cnt;

   assign phase     = {bus.phase_red, bus.phase_yellow, bus.phase_green};
   assign dbg_state = state;

   // Decode the current phase inputs and the per-edge decisions.
   always_comb begin
      legal   = (phase == PH_RED) || (phase == PH_YELLOW) || (phase == PH_GREEN);
      // Coming out of FAULT, any legal phase restarts timing, even the same one.
      entry   = legal && ((phase != prev_phase) || (state == S_FAULT));
      is_red  = (phase == PH_RED);
      // A request made while walk is already showing is considered served.
      ped_set = bus.ped_req && !bus.walk;
      grant   = is_red && (bus.ped_pending || bus.ped_req);
      case (phase)
         PH_RED:    load_val = RED_L;
         PH_YELLOW: load_val = YELLOW_L;
         default:   load_val = GREEN_L;
      endcase
      // Pending pedestrian caps the remaining green; the cap never lengthens it.
      if ((phase == PH_GREEN) && bus.ped_pending && (cnt > PED_L)) begin
         eff_cnt = PED_L;
      end else begin
         eff_cnt = cnt;
      end
   end

   // State, counter and registered outputs; phase entry takes priority over
   // an advance falling due on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= S_IDLE;
         prev_phase      <= 3'b000;
         cnt             <= '0;
         bus.advance     <= 1'b0;
         bus.walk        <= 1'b0;
         bus.ped_pending <= 1'b0;
         bus.fault       <= 1'b0;
      end else begin
         bus.advance <= 1'b0;
         if (legal) begin
            prev_phase <= phase;
         end
         if (!legal) begin
            // Counter is frozen; the next legal phase reloads it anyway.
            state     <= S_FAULT;
            bus.fault <= 1'b1;
            bus.walk  <= 1'b0;
            if (ped_set) begin
               bus.ped_pending <= 1'b1;
            end
         end else if (entry) begin
            state           <= S_COUNT;
            cnt             <= load_val;
            bus.fault       <= 1'b0;
            bus.walk        <= grant;
            bus.ped_pending <= grant ? 1'b0 : (bus.ped_pending | ped_set);
         end else begin
            bus.ped_pending <= bus.ped_pending | ped_set;
            case (state)
               S_COUNT: begin
                  if (eff_cnt <= ONE) begin
                     bus.advance <= 1'b1;
                     cnt         <= RETRY_L;
                     state       <= S_WAIT;
                  end else begin
                     cnt <= eff_cnt - ONE;
                  end
               end
               S_WAIT: begin
                  if (cnt <= ONE) begin
                     bus.advance <= 1'b1;
                     cnt         <= RETRY_L;
                  end else begin
                     cnt <= cnt - ONE;
                  end
               end
               default: begin
                  cnt <= cnt;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Bench for traffic_phase_timer: directed phase sequences, a deadline-based
// reference model checked on every falling edge, and hand-computed checks.
module tb_traffic_phase_timer;
   localparam int RED    = 20;
   localparam int GREEN  = 30;
   localparam int YEL    = 5;
   localparam int PED    = 8;
   localparam int RETRY  = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] dbg_state;
   int         errors = 0;
   int         checks = 0;
   int         exp_q[$];

   traffic_phase_timer_if bus();

   traffic_phase_timer #(
      .RED_CYCLES(RED), .GREEN_CYCLES(GREEN), .YELLOW_CYCLES(YEL),
      .PED_GREEN(PED), .RETRY_CYCLES(RETRY), .CNT_W(16)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus),
      .dbg_state(dbg_state)
   );

   // Clock.
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: absolute deadlines per phase rather than a counter.
   logic [2:0] m_prev = 3'b000;
   logic       m_fault = 1'b0, m_walk = 1'b0, m_pend = 1'b0, m_adv = 1'b0;
   longint     m_due = -1;
   longint     n = 0;

   function automatic int dur(input logic [2:0] ph);
      case (ph)
         3'b100:  return RED;
         3'b010:  return YEL;
         default: return GREEN;
      endcase
   endfunction

   always @(posedge clk or negedge reset_n) begin
      logic [2:0] ph;
      logic       set_req;
      logic       pend_before;
      if (!reset_n) begin
         m_prev = 3'b000; m_fault = 0; m_walk = 0; m_pend = 0; m_adv = 0;
         m_due = -1;
      end else begin
         ph = {bus.phase_red, bus.phase_yellow, bus.phase_green};
         set_req = bus.ped_req && !m_walk;
         m_adv = 0;
         if ($countones(ph) != 1) begin
            m_fault = 1; m_walk = 0; m_due = -1;
            m_pend = m_pend | set_req;
         end else begin
            if (ph != m_prev || m_fault) begin
               m_fault = 0;
               m_due = n + dur(ph);
               if (ph == 3'b100 && (m_pend || bus.ped_req)) begin
                  m_walk = 1; m_pend = 0;
               end else begin
                  m_walk = 0; m_pend = m_pend | set_req;
               end
            end else begin
               pend_before = m_pend;
               m_pend = m_pend | set_req;
               if (m_due >= 0) begin
                  if (ph == 3'b001 && pend_before && (m_due - n + 1) > PED)
                     m_due = n + PED - 1;
                  if (n == m_due) begin
                     m_adv = 1;
                     m_due = n + RETRY;
                  end
               end
            end
            m_prev = ph;
         end
         n++;
      end
   end

   // Compare DUT outputs with the model away from the active edge.
   always @(negedge clk) begin
      chk("model_advance", int'(bus.advance), int'(m_adv));
      chk("model_walk", int'(bus.walk), int'(m_walk));
      chk("model_ped_pending", int'(bus.ped_pending), int'(m_pend));
      chk("model_fault", int'(bus.fault), int'(m_fault));
   end

   // Driver tasks.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ph(input logic r, input logic y, input logic g);
      bus.phase_red = r; bus.phase_yellow = y; bus.phase_green = g;
   endtask

   // Edges (counted from the next one as 1) until advance is seen; 0 if never.
   task automatic count_adv(output int k);
      k = 0;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         #1;
         if (bus.advance) begin
            k = i;
            return;
         end
      end
   endtask

   task automatic expect_adv(input string name, input int exp);
      int k;
      exp_q.push_back(exp);
      count_adv(k);
      chk(name, k, exp_q.pop_front());
   endtask

   initial begin
      set_ph(0, 0, 0);
      bus.ped_req = 0;
      reset_n = 0;
      repeat (3) tick();
      chk("reset_advance", int'(bus.advance), 0);
      chk("reset_walk", int'(bus.walk), 0);
      chk("reset_ped_pending", int'(bus.ped_pending), 0);
      chk("reset_fault", int'(bus.fault), 0);

      // Red entry on the first edge after release, then yellow, then retries.
      set_ph(1, 0, 0);
      reset_n = 1;
      expect_adv("red_duration", RED + 1);
      set_ph(0, 1, 0);
      expect_adv("yellow_duration", YEL + 1);
      expect_adv("retry_1", RETRY);
      expect_adv("retry_2", RETRY);

      // Green shortened by a pedestrian request sampled at edge 3.
      set_ph(0, 0, 1);
      tick(); tick(); tick();
      bus.ped_req = 1;
      tick();
      bus.ped_req = 0;
      chk("ped_latched", int'(bus.ped_pending), 1);
      expect_adv("green_ped_short", 8);
      set_ph(1, 0, 0);
      tick();
      chk("red_walk_on", int'(bus.walk), 1);
      chk("red_ped_clear", int'(bus.ped_pending), 0);
      tick(); tick();
      set_ph(0, 1, 0);
      tick();
      chk("yellow_walk_off", int'(bus.walk), 0);

      // Illegal input mid-green, then full restart on the same green.
      set_ph(0, 0, 1);
      tick();
      repeat (5) tick();
      set_ph(1, 0, 1);
      tick();
      chk("fault_set", int'(bus.fault), 1);
      chk("fault_no_adv", int'(bus.advance), 0);
      repeat (3) tick();
      set_ph(0, 0, 1);
      tick();
      chk("fault_clear", int'(bus.fault), 0);
      expect_adv("green_restart", GREEN);

      // Button held across red while walk is on: request is absorbed.
      set_ph(0, 1, 0);
      tick();
      bus.ped_req = 1;
      set_ph(1, 0, 0);
      tick();
      chk("held_walk_on", int'(bus.walk), 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("held_no_pending", int'(bus.ped_pending), 0);
      end
      set_ph(0, 0, 1);
      tick();
      chk("held_walk_off", int'(bus.walk), 0);
      chk("held_still_clear", int'(bus.ped_pending), 0);
      tick();
      chk("held_pending_set", int'(bus.ped_pending), 1);
      bus.ped_req = 0;

      // Asynchronous reset mid-count with walk showing.
      set_ph(0, 1, 0);
      tick();
      set_ph(1, 0, 0);
      tick();
      chk("pre_reset_walk", int'(bus.walk), 1);
      repeat (3) tick();
      #2 reset_n = 0;
      #1;
      chk("async_advance", int'(bus.advance), 0);
      chk("async_walk", int'(bus.walk), 0);
      chk("async_ped_pending", int'(bus.ped_pending), 0);
      chk("async_fault", int'(bus.fault), 0);
      set_ph(0, 0, 1);
      @(negedge clk);
      reset_n = 1;
      expect_adv("post_reset_green", GREEN + 1);

      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
